dk48_cube_arbiter: RTL and testbench
====================================

// Module: dk48_cube_arbiter
// PURPOSE
//  - Shares one registered instance of the dk48 output-9 product term among NREQ requesters.
//  - Each requester presents a 15-bit input vector x[14:0] with a valid/ready handshake.
//  - A round-robin arbiter grants one requester per cycle.
//  - The cube result y0 returns on a single response channel tagged with the requester id.
//  - Sits between the benchmark stimulus engines and the shared evaluator.
//  - Makes the PLA term usable as a pipelined, back-pressured resource.
// PARAMETERS
//  NREQ   4   number of requesters, 2..8
//  IDW    2   response id width, >= clog2(NREQ)
// PORTS
//  clk        in   1          rising-edge clock
//  rst_n      in   1          asynchronous active-low reset
//  req_valid  in   NREQ       requester i has a vector pending
//  req_vec    in   NREQ*15    vector i in bits [15*i+14:15*i]; bit k = xk
//  req_ready  out  NREQ       one-hot grant; handshake when valid&ready
//  rsp_valid  out  1          response holds a result
//  rsp_y      out  1          evaluated y0
//  rsp_id     out  IDW        requester index of this result
//  rsp_ready  in   1          consumer accepts the response
//  hit_cnt    out  16         only with DK48_HITCNT_EN; count of rsp_y=1 handshakes
// BEHAVIOUR
//  - Cube function, decided:
//      y0 = (x2 ^ x8) & ~x9 & ~(x0|x1|x3|x4|x5|x6|x7|x10|x11|x12|x13|x14)
//  - Reset (async assert, sync deassert by the system):
//      rsp_valid=0, rsp_y=0, rsp_id=0, req_ready=0, rr_ptr=NREQ-1, hit_cnt=0.
//  - Slot free condition: slot_free = ~rsp_valid | rsp_ready.
//  - Arbitration is combinational each cycle.
//    - If slot_free, the winner is the first requester with req_valid=1, searching from rr_ptr+1 mod NREQ upward with wrap.
//    - req_ready = onehot(winner) when slot_free and at least one valid; otherwise 0.
//    - req_ready never depends on the winner's own req_ready.
//  - On grant: next edge loads rsp_y = y0(req_vec[winner]), rsp_id = winner, rsp_valid=1, rr_ptr = winner.
//  - Latency: 1 cycle from the accept edge to rsp_valid.
//  - Throughput: 1 result/cycle while rsp_ready=1.
//  - Pending response: rsp_valid=1 & rsp_ready=0 holds rsp_y and rsp_id stable, and all req_ready=0.
//  - Simultaneous response drain and new grant in one cycle: the response is consumed and the new result loads at the same edge. No bubble.
//  - Drain with no requester valid: rsp_valid clears at the next edge. rr_ptr is unchanged.
//  - Single requester valid: it wins every free cycle. There is no forced idle.
//  - Requester behaviour is undefined if req_valid drops before its handshake. The arbiter re-arbitrates each cycle and holds no grant state.
//  - State encoding (implicit 2-state): EMPTY (rsp_valid=0), FULL (rsp_valid=1).
//    - EMPTY -> FULL on grant.
//    - FULL -> FULL on drain+grant or on stall.
//    - FULL -> EMPTY on drain without grant.
//  - Reset mid-operation: a pending response is dropped and the pointer returns to NREQ-1, so requester 0 has priority first.
// CONFIGURATION
//  - DK48_HITCNT_EN defined:
//    - hit_cnt port exists.
//    - It increments by 1 on each rsp_valid&rsp_ready with rsp_y=1.
//    - It saturates at 16'hFFFF and clears on reset.
//  - DK48_HITCNT_EN undefined: the hit_cnt port and its register are absent. All other behaviour is identical.
// TESTING
//  1. Reset, then NREQ=4, req_valid=4'b0001, vec0=15'h0004 (x2=1), rsp_ready=1.
//     -> req_ready=4'b0001; next cycle rsp_valid=1, rsp_y=1, rsp_id=0.
//  2. Cube truth points, one requester at a time:
//     15'h0100 -> y=1; 15'h0104 -> 0; 15'h0300 -> 0; 15'h0000 -> 0; 15'h4004 -> 0; 15'h0005 -> 0.
//  3. All four valid continuously, rsp_ready=1.
//     -> grants in order 0,1,2,3,0,... with one response per cycle and rsp_id matching the grant.
//  4. rsp_ready=0 for 3 cycles with a pending result.
//     -> rsp_valid/rsp_y/rsp_id stable and req_ready=0 throughout.
//     -> Raising rsp_ready grants the next requester in the same cycle.
//  5. Assert rst_n=0 asynchronously mid-cycle while FULL.
//     -> rsp_valid drops immediately.
//     -> After release with all valid, the first grant is requester 0.
//  6. With DK48_HITCNT_EN: stream 10 hits and 5 misses -> hit_cnt=10.
//     Preload 16'hFFFF via 65535 hits, then 1 more hit -> stays 16'hFFFF.

Source files
------------

// File: rtl/dk48_cube_arbiter.sv
// Round-robin arbiter sharing one registered dk48 output-9 cube evaluator among NREQ requesters.
// Optional hit counter enabled by defining DK48_HITCNT_EN.
//
// state | meaning
// EMPTY | no result held, rsp_valid=0
// FULL  | result held in rsp_y/rsp_id, rsp_valid=1
module dk48_cube_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*15-1:0] req_vec,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  output logic              rsp_y,
  output logic [IDW-1:0]    rsp_id,
  input  logic              rsp_ready
`ifdef DK48_HITCNT_EN
  ,
  output logic [15:0]       hit_cnt
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t          state_q, state_d;
  logic            rsp_y_q, rsp_y_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;

  logic            slot_free;
  logic            found;
  logic            grant;
  logic [PW-1:0]   winner;
  logic [PW-1:0]   idx;
  logic [14:0]     win_vec;

  function automatic logic cube_y0(input logic [14:0] x);
    return (x[2] ^ x[8]) & ~x[9] & ~(|{x[14:10], x[7:3], x[1:0]});
  endfunction

  assign rsp_valid = (state_q == FULL);
  assign rsp_y     = rsp_y_q;
  assign rsp_id    = rsp_id_q;
  assign slot_free = ~rsp_valid | rsp_ready;

  // Search starts one past the last winner so each requester gets a turn.
  always_comb begin
    found   = 1'b0;
    winner  = '0;
    idx     = '0;
    win_vec = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = PW'((int'(rr_ptr_q) + i) % NREQ);
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (winner == PW'(i)) win_vec = req_vec[15*i +: 15];
    end
  end

  // Ready is forced low while reset is held so no handshake can occur in reset.
  assign grant     = slot_free & found & rst_n;
  assign req_ready = grant ? (NREQ'(1) << winner) : '0;

  always_comb begin
    state_d  = state_q;
    rsp_y_d  = rsp_y_q;
    rsp_id_d = rsp_id_q;
    rr_ptr_d = rr_ptr_q;
    if (grant) begin
      state_d  = FULL;
      rsp_y_d  = cube_y0(win_vec);
      rsp_id_d = IDW'(winner);
      rr_ptr_d = winner;
    end else if (state_q == FULL && rsp_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      rsp_y_q  <= 1'b0;
      rsp_id_q <= '0;
      rr_ptr_q <= PW'(NREQ - 1);
    end else begin
      state_q  <= state_d;
      rsp_y_q  <= rsp_y_d;
      rsp_id_q <= rsp_id_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef DK48_HITCNT_EN
  logic [15:0] hit_cnt_q, hit_cnt_d;

  always_comb begin
    hit_cnt_d = hit_cnt_q;
    if (rsp_valid && rsp_ready && rsp_y_q && (hit_cnt_q != 16'hFFFF))
      hit_cnt_d = hit_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hit_cnt_q <= '0;
    else        hit_cnt_q <= hit_cnt_d;
  end

  assign hit_cnt = hit_cnt_q;
`endif

endmodule

// File: tb/tb_dk48_cube_arbiter.sv
// Directed self-checking bench for dk48_cube_arbiter (NREQ=4, IDW=2).
// Hit-counter checks run only when DK48_HITCNT_EN is defined.
module tb_dk48_cube_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [59:0] req_vec;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_y;
  logic [1:0]  rsp_id;
  logic        rsp_ready;
`ifdef DK48_HITCNT_EN
  logic [15:0] hit_cnt;
`endif

  logic [14:0] vec [4];
  int          n_cmp;
  int          n_bad;
  int          ptr;
  int          expw;
  int          last;
  logic        yexp [4];

  assign req_vec = {vec[3], vec[2], vec[1], vec[0]};

  dk48_cube_arbiter #(.NREQ(4), .IDW(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_vec   (req_vec),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_y     (rsp_y),
    .rsp_id    (rsp_id),
    .rsp_ready (rsp_ready)
`ifdef DK48_HITCNT_EN
    ,
    .hit_cnt   (hit_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [14:0] tv [6];
    logic        ty [6];
    int          r;
    n_cmp = 0;
    n_bad = 0;
    tv = '{15'h0100, 15'h0104, 15'h0300, 15'h0000, 15'h4004, 15'h0005};
    ty = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    rst_n     = 1'b0;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) vec[i] = 15'h0004;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_y", 32'(rsp_y), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    tick();
    tick();
    chk("rst_hold_valid", 32'(rsp_valid), 32'd0);
    req_valid = 4'b0000;
    rst_n     = 1'b1;
    tick();

    // Test 1: single requester, first result
    req_valid = 4'b0001;
    vec[0]    = 15'h0004;
    #1;
    chk("t1_req_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0000;
    chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t1_rsp_y", 32'(rsp_y), 32'd1);
    chk("t1_rsp_id", 32'(rsp_id), 32'd0);
    tick();
    chk("t1_drain", 32'(rsp_valid), 32'd0);

    // Test 2: cube truth points, one requester per cycle
    for (int k = 0; k < 6; k++) begin
      r = k % 4;
      vec[r]    = tv[k];
      req_valid = 4'(1 << r);
      #1;
      chk("t2_req_ready", 32'(req_ready), 32'(1 << r));
      tick();
      chk("t2_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("t2_rsp_y", 32'(rsp_y), 32'(ty[k]));
      chk("t2_rsp_id", 32'(rsp_id), 32'(r));
    end
    req_valid = 4'b0000;
    tick();
    chk("t2_drain", 32'(rsp_valid), 32'd0);
    ptr = 1;

    // Test 3: all four valid, round robin at one result per cycle
    vec[0] = 15'h0004; yexp[0] = 1'b1;
    vec[1] = 15'h0100; yexp[1] = 1'b1;
    vec[2] = 15'h0006; yexp[2] = 1'b0;
    vec[3] = 15'h0104; yexp[3] = 1'b0;
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      expw = (ptr + 1) % 4;
      #1;
      chk("t3_req_ready", 32'(req_ready), 32'(1 << expw));
      tick();
      chk("t3_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("t3_rsp_id", 32'(rsp_id), 32'(expw));
      chk("t3_rsp_y", 32'(rsp_y), 32'(yexp[expw]));
      ptr = expw;
    end

    // Test 4: stall for three cycles, then release
    last      = ptr;
    rsp_ready = 1'b0;
    #1;
    chk("t4_ready_stall", 32'(req_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t4_hold_valid", 32'(rsp_valid), 32'd1);
      chk("t4_hold_id", 32'(rsp_id), 32'(last));
      chk("t4_hold_y", 32'(rsp_y), 32'(yexp[last]));
      chk("t4_hold_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    expw = (last + 1) % 4;
    #1;
    chk("t4_release_ready", 32'(req_ready), 32'(1 << expw));
    tick();
    chk("t4_release_id", 32'(rsp_id), 32'(expw));
    chk("t4_release_y", 32'(rsp_y), 32'(yexp[expw]));

    // Test 5: asynchronous reset mid-cycle while FULL
    chk("t5_pre_full", 32'(rsp_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_valid", 32'(rsp_valid), 32'd0);
    chk("t5_async_id", 32'(rsp_id), 32'd0);
    chk("t5_async_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t5_first_grant", 32'(req_ready), 32'h1);
    tick();
    chk("t5_first_id", 32'(rsp_id), 32'd0);
    chk("t5_second_grant", 32'(req_ready), 32'h2);
    req_valid = 4'b0000;
    tick();
    tick();

`ifdef DK48_HITCNT_EN
    // Test 6: hit counting and saturation
    rst_n = 1'b0;
    #1;
    chk("t6_rst_hits", 32'(hit_cnt), 32'd0);
    rst_n = 1'b1;
    tick();
    req_valid = 4'b0001;
    for (int k = 0; k < 15; k++) begin
      vec[0] = (k % 3 == 2) ? 15'h0300 : 15'h0100;
      tick();
    end
    req_valid = 4'b0000;
    tick();
    tick();
    chk("t6_hits_10", 32'(hit_cnt), 32'd10);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    vec[0]    = 15'h0100;
    req_valid = 4'b0001;
    for (int k = 0; k < 65535; k++) tick();
    req_valid = 4'b0000;
    tick();
    tick();
    chk("t6_hits_max", 32'(hit_cnt), 32'hFFFF);
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0000;
    tick();
    tick();
    chk("t6_hits_sat", 32'(hit_cnt), 32'hFFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
